// File: rtl/curl_pkg.sv
// Shared Curl-P types, sizes and the round substitution box.
package curl_pkg;
    typedef logic [1:0] trit_t;

    localparam int STATE_TRITS = 729;
    localparam int IO_WORDS    = 9;
    localparam int WORD_TRITS  = 27;

    // Entry n is the result for (a + 3*b + 4); entry 0 is the rightmost.
    localparam logic [8:0][1:0] TT = {2'b00, 2'b01, 2'b11, 2'b00, 2'b11,
                                      2'b01, 2'b11, 2'b00, 2'b01};

    // Offset trit value by +1 so the table index stays non-negative; 2'b10 acts as -1.
    function automatic logic [3:0] trit_u(trit_t t);
        case (t)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    function automatic trit_t curl_sbox(trit_t a, trit_t b);
        logic [3:0] idx;
        idx = trit_u(a) + 4'd3 * trit_u(b);
        return TT[idx];
    endfunction
endpackage

// File: rtl/curl_round.sv
// One combinational Curl-P round over the full 729-trit state.
module curl_round
    import curl_pkg::*;
(
    input  logic [STATE_TRITS-1:0][1:0] s_i,
    output logic [STATE_TRITS-1:0][1:0] s_o
);
    // The index walk t(n+1) = t(n)+364 or t(n)-365 is simply 364*n mod 729.
    for (genvar i = 0; i < STATE_TRITS; i++) begin : g_trit
        localparam int TA = (364 * i) % STATE_TRITS;
        localparam int TB = (364 * (i + 1)) % STATE_TRITS;
        assign s_o[i] = curl_sbox(s_i[TA], s_i[TB]);
    end
endmodule

// File: rtl/curl_transform_multi.sv
// Curl-P sponge state with multi-round-per-clock transform, bus access and status.
// Optional CURL_TRIT_CHECK_EN adds a sticky flag for writes carrying the invalid 2'b10 trit.
module curl_transform_multi
    import curl_pkg::*;
#(
    parameter int DATA_WIDTH       = 54,
    parameter int STATE_WORDS      = 27,
    parameter int DEFAULT_ROUNDS   = 81,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic                  i_rd,
    input  logic [3:0]            i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic [6:0]            i_rounds,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_rvalid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [6:0] RPC = 7'(ROUNDS_PER_CYCLE);

    fsm_t fsm_q, fsm_d;
    logic [STATE_WORDS-1:0][DATA_WIDTH-1:0] state_q, state_d;
    logic [6:0] rem_q, rem_d, k;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic rvalid_q, rvalid_d, done_q, done_d, addr_ok;

    logic [STATE_TRITS-1:0][1:0] trits;
    logic [ROUNDS_PER_CYCLE-1:0][STATE_TRITS-1:0][1:0] outs;

    assign trits = state_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_stage
        logic [STATE_TRITS-1:0][1:0] s_in, s_out;
        if (j == 0) begin : g_first
            assign s_in = trits;
        end else begin : g_next
            assign s_in = g_stage[j-1].s_out;
        end
        curl_round u_round (.s_i(s_in), .s_o(s_out));
        assign outs[j] = s_out;
    end

    assign addr_ok = (i_addr < 4'(IO_WORDS));
    assign k       = (rem_q < RPC) ? rem_q : RPC;

`ifdef CURL_TRIT_CHECK_EN
    logic err_q, err_d, bad_trit;
    always_comb begin
        bad_trit = 1'b0;
        for (int t = 0; t < DATA_WIDTH / 2; t++)
            bad_trit = bad_trit | (i_data[2*t+1] & ~i_data[2*t]);
    end
`endif

    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        rvalid_d = i_rd;
        rdata_d  = rdata_q;
`ifdef CURL_TRIT_CHECK_EN
        err_d    = err_q;
`endif
        if (i_rd) rdata_d = addr_ok ? state_q[i_addr] : '0;
        case (fsm_q)
            IDLE: begin
                // Clear beats both a write and a start in the same cycle.
                if (i_clear) begin
                    state_d = '0;
`ifdef CURL_TRIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                end else begin
                    if (i_we && addr_ok) begin
                        state_d[i_addr] = i_data;
`ifdef CURL_TRIT_CHECK_EN
                        err_d = err_q | bad_trit;
`endif
                    end
                    if (i_start) begin
                        rem_d = (i_rounds == 7'd0) ? 7'(DEFAULT_ROUNDS) : i_rounds;
                        fsm_d = RUN;
                    end
                end
            end
            RUN: begin
                if (k != 7'd0) state_d = outs[k - 7'd1];
                rem_d = rem_q - k;
                if (rem_d == 7'd0) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fsm_q    <= IDLE;
            state_q  <= '0;
            rem_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef CURL_TRIT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
`ifdef CURL_TRIT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign o_data   = rdata_q;
    assign o_rvalid = rvalid_q;
    assign o_busy   = (fsm_q == RUN);
    assign o_done   = done_q;
`ifdef CURL_TRIT_CHECK_EN
    assign o_err    = err_q;
`else
    assign o_err    = 1'b0;
`endif
endmodule

// File: tb/tb_curl_transform_multi.sv
// Directed/random bench for curl_transform_multi against an array-based Curl-P model.
module tb_curl_transform_multi;
    localparam int RPC = 3;
`ifdef CURL_TRIT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_we = 1'b0, i_rd = 1'b0, i_clear = 1'b0, i_start = 1'b0;
    logic [3:0]  i_addr = '0;
    logic [53:0] i_data = '0;
    logic [6:0]  i_rounds = '0;
    logic [53:0] o_data;
    logic        o_rvalid, o_busy, o_done, o_err;

    int checks = 0;
    int errors = 0;

    logic [1:0] m [729];
    int tt [9] = '{1, 0, -1, 1, -1, 0, -1, 1, 0};

    curl_transform_multi #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_we(i_we), .i_rd(i_rd),
        .i_addr(i_addr), .i_data(i_data), .i_clear(i_clear), .i_start(i_start),
        .i_rounds(i_rounds), .o_data(o_data), .o_rvalid(o_rvalid),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dec(logic [1:0] t);
        return (t == 2'b00) ? 0 : ((t == 2'b01) ? 1 : -1);
    endfunction

    function automatic logic [1:0] enc(int v);
        return (v == 0) ? 2'b00 : ((v == 1) ? 2'b01 : 2'b11);
    endfunction

    task automatic model_round();
        logic [1:0] n [729];
        int t = 0, tn;
        for (int i = 0; i < 729; i++) begin
            tn = (t < 365) ? t + 364 : t - 365;
            n[i] = enc(tt[dec(m[t]) + 3 * dec(m[tn]) + 4]);
            t = tn;
        end
        for (int i = 0; i < 729; i++) m[i] = n[i];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 729; i++) m[i] = 2'b00;
    endtask

    function automatic logic [53:0] mword(int w);
        logic [53:0] r;
        for (int k = 0; k < 27; k++) r[2*k +: 2] = m[27*w + k];
        return r;
    endfunction

    task automatic model_write(int a, logic [53:0] d);
        if (a < 9) for (int k = 0; k < 27; k++) m[27*a + k] = d[2*k +: 2];
    endtask

    function automatic logic [53:0] rand_word();
        logic [53:0] r;
        for (int k = 0; k < 27; k++)
            case ($urandom_range(0, 2))
                0:       r[2*k +: 2] = 2'b00;
                1:       r[2*k +: 2] = 2'b01;
                default: r[2*k +: 2] = 2'b11;
            endcase
        return r;
    endfunction

    task automatic write(input int a, input logic [53:0] d);
        @(negedge i_clk); i_we = 1'b1; i_addr = 4'(a); i_data = d;
        @(negedge i_clk); i_we = 1'b0;
        model_write(a, d);
    endtask

    task automatic rd(input int a, input string tag);
        @(negedge i_clk); i_rd = 1'b1; i_addr = 4'(a);
        @(negedge i_clk); i_rd = 1'b0;
        chk({tag, " rvalid"}, 64'(o_rvalid), 64'd1);
        chk({tag, " data"}, 64'(o_data), (a < 9) ? 64'(mword(a)) : 64'd0);
    endtask

    task automatic check_all(input string tag);
        for (int w = 0; w < 9; w++) rd(w, $sformatf("%s w%0d", tag, w));
    endtask

    task automatic clear();
        @(negedge i_clk); i_clear = 1'b1;
        @(negedge i_clk); i_clear = 1'b0;
        model_clear();
    endtask

    // Counts busy cycles starting at first-busy negedge; expects done right after.
    task automatic wait_done(input int already, input int rr, input string tag);
        int cnt = already;
        while (o_busy && cnt < 300) begin
            cnt++;
            @(negedge i_clk);
        end
        chk({tag, " busy cycles"}, 64'(cnt), 64'((rr + RPC - 1) / RPC));
        chk({tag, " done"}, 64'(o_done), 64'd1);
        @(negedge i_clk);
        chk({tag, " done pulse"}, 64'(o_done), 64'd0);
    endtask

    task automatic run(input logic [6:0] r, input string tag);
        int rr = (r == 7'd0) ? 81 : int'(r);
        @(negedge i_clk); i_start = 1'b1; i_rounds = r;
        @(negedge i_clk); i_start = 1'b0;
        wait_done(0, rr, tag);
        repeat (rr) model_round();
    endtask

    initial begin
        logic [53:0] pre0, wd;
        bit saw_done;
        model_clear();
        repeat (2) @(negedge i_clk);
        chk("rst data", 64'(o_data), 64'd0);
        chk("rst rvalid", 64'(o_rvalid), 64'd0);
        chk("rst busy", 64'(o_busy), 64'd0);
        chk("rst done", 64'(o_done), 64'd0);
        chk("rst err", 64'(o_err), 64'd0);
        i_rst_n = 1'b1;
        rd(0, "rst rd0");
        rd(12, "oob rd");

        // Curl-P-81 from the zero state.
        run(7'd0, "r81");
        check_all("r81");

        clear();
        rd(4, "clr");

        for (int w = 0; w < 9; w++) write(w, rand_word());
        run(7'd28, "r28");
        check_all("r28");

        // Writes, starts and clears during busy are ignored; reads are honoured.
        pre0 = mword(0);
        @(negedge i_clk); i_start = 1'b1; i_rounds = 7'd30;
        @(negedge i_clk); i_start = 1'b0; i_rd = 1'b1; i_addr = 4'd0;
        chk("busy0", 64'(o_busy), 64'd1);
        @(negedge i_clk); i_rd = 1'b0; i_we = 1'b1; i_addr = 4'd5; i_data = 54'h15;
        chk("busy rd rvalid", 64'(o_rvalid), 64'd1);
        chk("busy rd data", 64'(o_data), 64'(pre0));
        @(negedge i_clk); i_we = 1'b0; i_start = 1'b1; i_rounds = 7'd5; i_clear = 1'b1;
        @(negedge i_clk); i_start = 1'b0; i_clear = 1'b0;
        wait_done(3, 30, "busyign");
        repeat (30) model_round();
        chk("no requeue", 64'(o_busy), 64'd0);
        check_all("busyign");

        // Write and start in the same cycle.
        wd = rand_word();
        @(negedge i_clk); i_we = 1'b1; i_addr = 4'd3; i_data = wd; i_start = 1'b1; i_rounds = 7'd7;
        @(negedge i_clk); i_we = 1'b0; i_start = 1'b0;
        model_write(3, wd);
        wait_done(0, 7, "we+start");
        repeat (7) model_round();
        check_all("we+start");

        // Clear wins over start.
        @(negedge i_clk); i_clear = 1'b1; i_start = 1'b1; i_rounds = 7'd5;
        @(negedge i_clk); i_clear = 1'b0; i_start = 1'b0;
        model_clear();
        chk("clr+start busy", 64'(o_busy), 64'd0);
        rd(2, "clr+start");

        // Invalid trit: still written, flagged when checking is built in, acts as -1.
        write(1, 54'h2);
        chk("err set", 64'(o_err), 64'(ERR_EN));
        write(2, rand_word());
        chk("err sticky", 64'(o_err), 64'(ERR_EN));
        rd(1, "raw 10");
        run(7'd1, "r1bad");
        check_all("r1bad");
        chk("err after run", 64'(o_err), 64'(ERR_EN));
        clear();
        chk("err cleared", 64'(o_err), 64'd0);

        // Address beyond the visible window is ignored.
        write(9, 54'h3FFF);
        write(0, rand_word());
        check_all("oob wr");

        // Reset partway through a run abandons it.
        @(negedge i_clk); i_start = 1'b1; i_rounds = 7'd81;
        @(negedge i_clk); i_start = 1'b0;
        repeat (13) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk); i_rst_n = 1'b1;
        model_clear();
        chk("midrst busy", 64'(o_busy), 64'd0);
        chk("midrst done", 64'(o_done), 64'd0);
        chk("midrst data", 64'(o_data), 64'd0);
        chk("midrst rvalid", 64'(o_rvalid), 64'd0);
        chk("midrst err", 64'(o_err), 64'd0);
        saw_done = 1'b0;
        rd(0, "midrst rd0");
        repeat (30) begin
            @(negedge i_clk);
            if (o_done || o_busy) saw_done = 1'b1;
        end
        chk("midrst no done", 64'(saw_done), 64'd0);

        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 9; w++) write(w, rand_word());
            run(7'($urandom_range(1, 127)), $sformatf("rnd%0d", n));
            check_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
